// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - write-back source indices and load size codes
package wb_pkg;

  localparam int SRC_RD        = 0;
  localparam int SRC_SE1_32    = 1;
  localparam int SRC_MEMDATA   = 2;
  localparam int SRC_ALUOUT    = 3;
  localparam int SRC_LO        = 4;
  localparam int SRC_HI        = 5;
  localparam int SRC_REG227    = 6;
  localparam int SRC_LOADSIZE  = 7;
  localparam int SRC_ALUOUT_RD = 8;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry circular buffer with occupancy count and flush
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/wb_select_queue.sv
// rtl/wb_select_queue.sv - indexed write-back source select feeding a valid/ready queue
// Optional load-size formatting of source LOAD_SRC when WB_LOADSIZE_EN is defined.
module wb_select_queue
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_SRC    = 9,
  parameter int SEL_W      = 4,
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_SRC   = SRC_MEMDATA
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic [NUM_SRC*DATA_W-1:0]   in_src,
  input  logic [REG_ADDR_W-1:0]       in_rd,
  input  logic [1:0]                  in_size,
  input  logic                        in_unsigned,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [REG_ADDR_W-1:0]       out_rd,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        sel_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] fmt;
  logic              sel_ok;
  logic              accept;
  logic              push;
  logic              pop;
  logic [DATA_W+REG_ADDR_W-1:0] head;

  always_comb begin
    raw    = '0;
    sel_ok = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (in_sel == SEL_W'(k)) begin
        raw    = in_src[k*DATA_W +: DATA_W];
        sel_ok = 1'b1;
      end
    end
  end

`ifdef WB_LOADSIZE_EN
  always_comb begin
    fmt = raw;
    if (in_sel == SEL_W'(LOAD_SRC)) begin
      case (in_size)
        SZ_HALF: fmt = {{(DATA_W-16){~in_unsigned & raw[15]}}, raw[15:0]};
        SZ_BYTE: fmt = {{(DATA_W-8){~in_unsigned & raw[7]}}, raw[7:0]};
        default: fmt = raw;
      endcase
    end
  end
`else
  logic unused_load_ctl;
  assign unused_load_ctl = ^{in_size, in_unsigned, (LOAD_SRC == 0)};
  assign fmt = raw;
`endif

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready & ~flush;
  // Writes to $zero complete the handshake but never occupy a slot.
  assign push      = accept & (in_rd != '0);
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              sel_err <= 1'b0;
    else if (accept && !sel_ok) sel_err <= 1'b1;
  end

  wb_fifo #(
    .WIDTH (DATA_W + REG_ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   ({fmt, in_rd}),
    .rdata   (head),
    .count   (count)
  );

  assign out_data = head[DATA_W+REG_ADDR_W-1:REG_ADDR_W];
  assign out_rd   = head[REG_ADDR_W-1:0];

endmodule

// File: tb/tb_wb_select_queue.sv
// tb/tb_wb_select_queue.sv - directed vector bench for wb_select_queue
module tb_wb_select_queue;

  localparam int DW = 32;
  localparam int NS = 9;

`ifdef WB_LOADSIZE_EN
  localparam logic [31:0] EXP_H_S = 32'hFFFF_80F0;
  localparam logic [31:0] EXP_B_U = 32'h0000_00F0;
  localparam logic [31:0] EXP_B_S = 32'hFFFF_FFF0;
`else
  localparam logic [31:0] EXP_H_S = 32'h0000_80F0;
  localparam logic [31:0] EXP_B_U = 32'h0000_80F0;
  localparam logic [31:0] EXP_B_S = 32'h0000_80F0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sel;
  logic [NS*DW-1:0] in_src;
  logic [4:0]       in_rd;
  logic [1:0]       in_size;
  logic             in_unsigned;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [4:0]       out_rd;
  logic [1:0]       count;
  logic             sel_err;

  always #5 clk = ~clk;

  wb_select_queue dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .in_src      (in_src),
    .in_rd       (in_rd),
    .in_size     (in_size),
    .in_unsigned (in_unsigned),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rd      (out_rd),
    .count       (count),
    .sel_err     (sel_err)
  );

  typedef struct {
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] src_vals [NS];
  int          checks = 0;
  int          failures = 0;
  logic        err_model;
  logic        exp_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  initial begin
    src_vals = '{32'hDEAD_0000, 32'hFFFF_FFFE, 32'h0000_80F0, 32'h1234_5678, 32'hCAFE_0004,
                 32'hBEEF_0005, 32'h0000_0006, 32'h7777_0007, 32'h8888_0008};
    for (int k = 0; k < NS; k++) in_src[k*DW +: DW] = src_vals[k];

    vecs.push_back('{4'd3,  5'd8,  2'b00, 1'b0, 32'h1234_5678});
    vecs.push_back('{4'd0,  5'd31, 2'b00, 1'b0, 32'hDEAD_0000});
    vecs.push_back('{4'd8,  5'd17, 2'b00, 1'b0, 32'h8888_0008});
    vecs.push_back('{4'd1,  5'd4,  2'b01, 1'b0, 32'hFFFF_FFFE});
    vecs.push_back('{4'd2,  5'd5,  2'b01, 1'b0, EXP_H_S});
    vecs.push_back('{4'd2,  5'd6,  2'b10, 1'b1, EXP_B_U});
    vecs.push_back('{4'd2,  5'd7,  2'b10, 1'b0, EXP_B_S});
    vecs.push_back('{4'd2,  5'd12, 2'b00, 1'b0, 32'h0000_80F0});
    vecs.push_back('{4'd2,  5'd13, 2'b11, 1'b1, 32'h0000_80F0});
    vecs.push_back('{4'd3,  5'd0,  2'b00, 1'b0, 32'h0000_0000});
    vecs.push_back('{4'd9,  5'd20, 2'b00, 1'b0, 32'h0000_0000});
    vecs.push_back('{4'd12, 5'd3,  2'b00, 1'b0, 32'h0000_0000});
    vecs.push_back('{4'd15, 5'd0,  2'b00, 1'b0, 32'h0000_0000});

    reset_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_rd = '0; in_size = '0;
    in_unsigned = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Single-entry vectors: push, check head one cycle later, pop.
    err_model = 1'b0;
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      in_sel = vecs[i].sel; in_rd = vecs[i].rd; in_size = vecs[i].size;
      in_unsigned = vecs[i].uns; in_valid = 1'b1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      err_model = err_model | (vecs[i].sel >= 4'(NS));
      exp_n = (vecs[i].rd != 5'd0);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(exp_n));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(exp_n));
      chk($sformatf("v%0d_out_data", i), out_data, exp_n ? vecs[i].exp : 32'd0);
      chk($sformatf("v%0d_out_rd", i), 32'(out_rd), exp_n ? 32'(vecs[i].rd) : 32'd0);
      chk($sformatf("v%0d_sel_err", i), 32'(sel_err), 32'(err_model));
      @(negedge clk);
      chk($sformatf("v%0d_drained", i), 32'(count), 32'd0);
    end

    // Fill to full, refuse third push, drain in order (also pop while full).
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 4'd4; in_rd = 5'd1; in_size = 2'b00;
    @(negedge clk);
    in_sel = 4'd5; in_rd = 5'd2;
    @(negedge clk);
    chk("full_count", 32'(count), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_sel = 4'd0; in_rd = 5'd3;
    @(negedge clk);
    chk("refused_count", 32'(count), 32'd2);
    chk("head1_rd", 32'(out_rd), 32'd1);
    chk("head1_data", out_data, 32'hCAFE_0004);
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_full_count", 32'(count), 32'd1);
    chk("head2_rd", 32'(out_rd), 32'd2);
    chk("head2_data", out_data, 32'hBEEF_0005);
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Simultaneous push/pop at count 1, then flush with a pending request.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 4'd0; in_rd = 5'd9;
    @(negedge clk);
    chk("pp_pre_count", 32'(count), 32'd1);
    in_sel = 4'd8; in_rd = 5'd10; out_ready = 1'b1;
    @(negedge clk);
    chk("pp_count", 32'(count), 32'd1);
    chk("pp_head_rd", 32'(out_rd), 32'd10);
    chk("pp_head_data", out_data, 32'h8888_0008);
    in_sel = 4'd3; in_rd = 5'd11; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_sel_err", 32'(sel_err), 32'd1);
    @(negedge clk);
    chk("flush_dropped", 32'(count), 32'd0);

    // Asynchronous reset in the middle of a transfer.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 4'd3; in_rd = 5'd4;
    @(negedge clk);
    chk("mid_pre_count", 32'(count), 32'd1);
    in_rd = 5'd5;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_sel_err", 32'(sel_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
